// File: rtl/mem_compare_checker.sv
// -----------------------------------------------------------------------------
// mem_compare_checker
//
// Registered memory-test comparator. Each accepted beat compares generator
// data against memory read-back under a per-bit ignore mask. Session
// statistics are kept for the test controller, which reads them after
// each sweep.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           one-cycle pulse: clear statistics, open a session
//   cmp_valid       beat qualifier for addr/data_gen/data_mem/mask/cmp_last
//   cmp_last        final beat of the session
//   addr            beat address tag
//   data_gen        expected data
//   data_mem        data read from memory
//   mask            per-bit ignore mask (1 = don't care)
//   is_equal        registered per-beat compare result, held between beats
//   res_valid       single-cycle pulse qualifying is_equal
//   busy            session open (RUN)
//   done            session closed by a last beat (DONE)
//   fail            sticky: at least one mismatch this session
//   err_cnt         saturating mismatch count
//   first_err_addr  address of the first mismatching beat
//   first_err_syn   masked XOR syndrome of the first mismatching beat
// -----------------------------------------------------------------------------
module mem_compare_checker #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     cmp_valid,
  input  logic                     cmp_last,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]    data_gen,
  input  logic [DATA_WIDTH-1:0]    data_mem,
  input  logic [DATA_WIDTH-1:0]    mask,
  output logic                     is_equal,
  output logic                     res_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [DATA_WIDTH-1:0]    first_err_syn
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic                     is_equal_q, is_equal_d;
  logic                     res_valid_q, res_valid_d;
  logic                     fail_q, fail_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]    first_addr_q, first_addr_d;
  logic [DATA_WIDTH-1:0]    first_syn_q, first_syn_d;

  logic [DATA_WIDTH-1:0]    syndrome;
  logic                     beat_match;
  logic                     beat_acc;

  // Masked-out bits can never contribute to a mismatch.
  assign syndrome   = (data_gen ^ data_mem) & ~mask;
  assign beat_match = (syndrome == '0);

  // start has priority: a beat arriving with start belongs to no session.
  assign beat_acc = (state_q == ST_RUN) && cmp_valid && !start;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (start)                     state_d = ST_RUN;
        else if (cmp_valid && cmp_last) state_d = ST_DONE;
      end
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Compare result and session statistics
  // ---------------------------------------------------------------------------
  always_comb begin
    is_equal_d   = is_equal_q;
    res_valid_d  = 1'b0;
    fail_d       = fail_q;
    err_cnt_d    = err_cnt_q;
    first_addr_d = first_addr_q;
    first_syn_d  = first_syn_q;

    if (start) begin
      is_equal_d   = 1'b0;
      fail_d       = 1'b0;
      err_cnt_d    = '0;
      first_addr_d = '0;
      first_syn_d  = '0;
    end else if (beat_acc) begin
      res_valid_d = 1'b1;
      is_equal_d  = beat_match;
      if (!beat_match) begin
        fail_d = 1'b1;
        // Saturate rather than wrap so a long failing sweep never reads as clean.
        if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
        // Only the first failure of the session is recorded.
        if (!fail_q) begin
          first_addr_d = addr;
          first_syn_d  = syndrome;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here is reset asynchronously because reset must
  // discard a session's statistics immediately, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      is_equal_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      fail_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_addr_q <= '0;
      first_syn_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, so ordering inside this block cannot matter.
      state_q      <= state_d;
      is_equal_q   <= is_equal_d;
      res_valid_q  <= res_valid_d;
      fail_q       <= fail_d;
      err_cnt_q    <= err_cnt_d;
      first_addr_q <= first_addr_d;
      first_syn_q  <= first_syn_d;
    end
  end

  // busy/done come straight from the state register, so they change at the
  // same edge that registers the last beat's result.
  assign is_equal       = is_equal_q;
  assign res_valid      = res_valid_q;
  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign fail           = fail_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_addr_q;
  assign first_err_syn  = first_syn_q;

endmodule
